cdc_fifo_wr_ctrl: RTL and testbench

Write-side control stage of the AXI4 interconnect clock-domain-crossing FIFO. It consumes the local write-pointer Gray count and the read-domain Gray pointer, and resynchronises the read pointer into the write clock domain. It derives full, almost-full, fill level, RAM write address and the increment strobe that drives the write-side Gray-code counter. It also flags overflow attempts.

---
 rtl/cdc_fifo_wr_ctrl.sv | 87 ++++++++
 tb/tb_cdc_fifo_wr_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_fifo_wr_ctrl.sv
// Write-side control of the CDC FIFO: resynchronises the read-domain Gray pointer
// and derives full, almost-full, fill level, RAM write address and the write strobe.
module cdc_fifo_wr_ctrl #(
  parameter int  ADDR_WIDTH  = 4,
  parameter int  SYNC_STAGES = 2,
  parameter int  AF_THRESH   = 12,
  localparam int PTR_W       = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  asysRst,
  input  logic                  wrValid,
  output logic                  wrReady,
  output logic                  wrInc,
  output logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [PTR_W-1:0]      wrPtrGray,
  input  logic [PTR_W-1:0]      rdPtrGray,
  output logic [PTR_W-1:0]      rdPtrGraySync,
  output logic [PTR_W-1:0]      fillLevel,
  output logic                  almostFull,
  output logic                  ovfErr,
  input  logic                  clrErr
);

  localparam logic [PTR_W-1:0] DEPTH    = PTR_W'(1) << ADDR_WIDTH;
  localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(AF_THRESH);

  logic [PTR_W-1:0] sync_q [SYNC_STAGES];
  logic [PTR_W-1:0] wr_bin;
  logic [PTR_W-1:0] rd_bin;
  logic [PTR_W-1:0] level_now;
  logic             full;

  function automatic logic [PTR_W-1:0] gray_to_bin(input logic [PTR_W-1:0] gray);
    logic [PTR_W-1:0] bin;
    bin[PTR_W-1] = gray[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // NOTE: the synchroniser chain is an array of flops, not a RAM, so it is reset
  // like any other register; rdPtrGraySync must read 0 while asysRst is low.
  always_ff @(posedge clk or negedge asysRst) begin
    if (!asysRst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rdPtrGray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rdPtrGraySync = sync_q[SYNC_STAGES-1];

  assign wr_bin    = gray_to_bin(wrPtrGray);
  assign rd_bin    = gray_to_bin(rdPtrGraySync);
  // Modulo subtraction keeps the wrap bit, so full and empty stay distinct.
  assign level_now = wr_bin - rd_bin;
  assign full      = (level_now == DEPTH);

  assign wrAddr  = wr_bin[ADDR_WIDTH-1:0];
  assign wrReady = ~full;
  assign wrInc   = wrValid & ~full;

  // NOTE: non-blocking assignments so every status flop samples the same
  // pre-edge level_now, independent of evaluation order.
  always_ff @(posedge clk or negedge asysRst) begin
    if (!asysRst) begin
      fillLevel  <= '0;
      almostFull <= 1'b0;
      ovfErr     <= 1'b0;
    end else begin
      fillLevel  <= level_now;
      almostFull <= (level_now >= AF_LEVEL);
      if (wrValid && full) begin
        ovfErr <= 1'b1;
      end else if (clrErr) begin
        ovfErr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdc_fifo_wr_ctrl.sv
// Bench for cdc_fifo_wr_ctrl: two instances (2- and 3-stage synchroniser) share
// stimulus; an integer-count model with a read-pointer history predicts outputs.
module tb_cdc_fifo_wr_ctrl;
  localparam int AW    = 3;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic          clk = 1'b0;
  logic          asysRst = 1'b1;
  logic          wrValid = 1'b0;
  logic          clrErr = 1'b0;
  logic [PW-1:0] rdPtrGray = '0;
  logic [PW-1:0] wr_gray [2];
  logic          wr_ready [2];
  logic          wr_inc [2];
  logic          almost_full [2];
  logic          ovf_err [2];
  logic [AW-1:0] wr_addr [2];
  logic [PW-1:0] rd_sync [2];
  logic [PW-1:0] fill_level [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model state: binary counts, history of rdPtrGray seen at each edge.
  int         wr_cnt [2];
  int         rd_cnt;
  logic [3:0] rd_hist [$];
  int         exp_fill [2];
  bit         exp_af [2];
  bit         exp_ovf [2];
  int         inc_seen [2];

  always #5 clk = ~clk;

  cdc_fifo_wr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(2), .AF_THRESH(AF)) u_dut2 (
    .clk(clk), .asysRst(asysRst), .wrValid(wrValid), .wrReady(wr_ready[0]),
    .wrInc(wr_inc[0]), .wrAddr(wr_addr[0]), .wrPtrGray(wr_gray[0]),
    .rdPtrGray(rdPtrGray), .rdPtrGraySync(rd_sync[0]), .fillLevel(fill_level[0]),
    .almostFull(almost_full[0]), .ovfErr(ovf_err[0]), .clrErr(clrErr)
  );

  cdc_fifo_wr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(3), .AF_THRESH(AF)) u_dut3 (
    .clk(clk), .asysRst(asysRst), .wrValid(wrValid), .wrReady(wr_ready[1]),
    .wrInc(wr_inc[1]), .wrAddr(wr_addr[1]), .wrPtrGray(wr_gray[1]),
    .rdPtrGray(rdPtrGray), .rdPtrGraySync(rd_sync[1]), .fillLevel(fill_level[1]),
    .almostFull(almost_full[1]), .ovfErr(ovf_err[1]), .clrErr(clrErr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] gray_enc(input int n);
    return 4'((n ^ (n >> 1)) & 15);
  endfunction

  // Decode by searching for the count whose Gray code matches.
  function automatic int gray_dec(input logic [3:0] g);
    for (int n = 0; n < 16; n++) begin
      if (gray_enc(n) == g) return n;
    end
    return 0;
  endfunction

  // One clock: drive inputs, compare at negedge, advance the model after posedge.
  task automatic step(input logic v, input logic clr, input bit rd_adv);
    logic [3:0] sync_e;
    int         lvl;
    bit         full_e;
    int         nxt_fill [2];
    bit         nxt_af [2];
    bit         nxt_ovf [2];
    bit         inc_e [2];
    wrValid = v;
    clrErr  = clr;
    if (rd_adv) rd_cnt = (rd_cnt + 1) % 16;
    rdPtrGray = gray_enc(rd_cnt);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int s;
      s      = k + 2;
      sync_e = (rd_hist.size() >= s) ? rd_hist[rd_hist.size() - s] : 4'd0;
      lvl    = (wr_cnt[k] - gray_dec(sync_e) + 16) % 16;
      full_e = (lvl == DEPTH);
      inc_e[k] = v && !full_e;
      check($sformatf("sync s%0d c%0d", s, cyc), 32'(rd_sync[k]), 32'(sync_e));
      check($sformatf("ready s%0d c%0d", s, cyc), 32'(wr_ready[k]), 32'(!full_e));
      check($sformatf("inc s%0d c%0d", s, cyc), 32'(wr_inc[k]), 32'(inc_e[k]));
      check($sformatf("addr s%0d c%0d", s, cyc), 32'(wr_addr[k]), 32'(wr_cnt[k] % DEPTH));
      check($sformatf("fill s%0d c%0d", s, cyc), 32'(fill_level[k]), 32'(exp_fill[k]));
      check($sformatf("af s%0d c%0d", s, cyc), 32'(almost_full[k]), 32'(exp_af[k]));
      check($sformatf("ovf s%0d c%0d", s, cyc), 32'(ovf_err[k]), 32'(exp_ovf[k]));
      if (wr_inc[k]) inc_seen[k]++;
      nxt_fill[k] = lvl;
      nxt_af[k]   = (lvl >= AF);
      nxt_ovf[k]  = (v && full_e) ? 1'b1 : (clr ? 1'b0 : exp_ovf[k]);
    end
    @(posedge clk);
    rd_hist.push_back(rdPtrGray);
    if (rd_hist.size() > 8) void'(rd_hist.pop_front());
    for (int k = 0; k < 2; k++) begin
      exp_fill[k] = nxt_fill[k];
      exp_af[k]   = nxt_af[k];
      exp_ovf[k]  = nxt_ovf[k];
      if (inc_e[k]) wr_cnt[k] = (wr_cnt[k] + 1) % 16;
    end
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) wr_gray[k] = gray_enc(wr_cnt[k]);
  endtask

  // Assert reset mid-cycle and check outputs before any edge arrives.
  task automatic do_reset();
    @(posedge clk);
    #3;
    wrValid   = 1'b0;
    clrErr    = 1'b0;
    rd_cnt    = 0;
    rdPtrGray = '0;
    for (int k = 0; k < 2; k++) begin
      wr_cnt[k]  = 0;
      wr_gray[k] = '0;
    end
    asysRst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst sync s%0d", k + 2), 32'(rd_sync[k]), 32'd0);
      check($sformatf("rst fill s%0d", k + 2), 32'(fill_level[k]), 32'd0);
      check($sformatf("rst af s%0d", k + 2), 32'(almost_full[k]), 32'd0);
      check($sformatf("rst ovf s%0d", k + 2), 32'(ovf_err[k]), 32'd0);
      check($sformatf("rst ready s%0d", k + 2), 32'(wr_ready[k]), 32'd1);
      check($sformatf("rst inc s%0d", k + 2), 32'(wr_inc[k]), 32'd0);
      check($sformatf("rst addr s%0d", k + 2), 32'(wr_addr[k]), 32'd0);
      exp_fill[k] = 0;
      exp_af[k]   = 1'b0;
      exp_ovf[k]  = 1'b0;
      inc_seen[k] = 0;
    end
    rd_hist.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    asysRst = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) wr_gray[k] = '0;

    // Fill from empty: eight accepted writes, then blocked requests.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("fill pulses s%0d", k + 2), 32'(inc_seen[k]), 32'd8);
      check($sformatf("fill level s%0d", k + 2), 32'(fill_level[k]), 32'd8);
      check($sformatf("fill ready s%0d", k + 2), 32'(wr_ready[k]), 32'd0);
      check($sformatf("fill af s%0d", k + 2), 32'(almost_full[k]), 32'd1);
      check($sformatf("fill ovf s%0d", k + 2), 32'(ovf_err[k]), 32'd1);
    end

    // Drain release: one read; space returns after the synchroniser depth.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("drain sync s2", 32'(rd_sync[0]), 32'd1);
    check("drain ready s2", 32'(wr_ready[0]), 32'd1);
    check("drain fill s2", 32'(fill_level[0]), 32'd8);
    check("drain sync s3 early", 32'(rd_sync[1]), 32'd0);
    check("drain ready s3 early", 32'(wr_ready[1]), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("drain fill s2 late", 32'(fill_level[0]), 32'd7);
    check("drain af s2", 32'(almost_full[0]), 32'd1);
    check("drain sync s3", 32'(rd_sync[1]), 32'd1);
    check("drain ready s3", 32'(wr_ready[1]), 32'd1);

    // Error clear without a blocked write, then clear losing to a new set.
    step(1'b0, 1'b1, 1'b0);
    check("clr ovf s2", 32'(ovf_err[0]), 32'd0);
    check("clr ovf s3", 32'(ovf_err[1]), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("set wins s2", 32'(ovf_err[0]), 32'd1);
    check("set wins s3", 32'(ovf_err[1]), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    check("clr again s2", 32'(ovf_err[0]), 32'd0);

    // Wrap: write count 15 -> 0 -> 1 with read count 9.
    do_reset();
    rd_cnt = 9;
    for (int k = 0; k < 2; k++) begin
      wr_cnt[k]  = 15;
      wr_gray[k] = gray_enc(15);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("wrap fill7 s%0d", k + 2), 32'(fill_level[k]), 32'd7);
      check($sformatf("wrap ready s%0d", k + 2), 32'(wr_ready[k]), 32'd1);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("wrap fill8 s%0d", k + 2), 32'(fill_level[k]), 32'd8);
      check($sformatf("wrap full s%0d", k + 2), 32'(wr_ready[k]), 32'd0);
    end

    // Random traffic, write-heavy then read-heavy, with a reset in between.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit v;
      bit clr;
      bit adv;
      if (i == 300) do_reset();
      v   = ($urandom_range(0, 99) < ((i < 300) ? 80 : 30));
      clr = ($urandom_range(0, 15) == 0);
      adv = ($urandom_range(0, 2) != 0) && (rd_cnt != wr_cnt[0]) && (rd_cnt != wr_cnt[1]);
      step(v, clr, adv);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
